lot_sensor_fsm: RTL and testbench
=================================

# lot_sensor_fsm

Upstream stage of the parking-lot occupancy counter. It watches the two photo sensors across the lot gate and decodes complete car passages. A full entry produces a single-cycle `enter` pulse and a full exit produces a single-cycle `exit` pulse; these drive the counter's `inc` and `dec` directly. The block synchronizes and debounces the raw sensor lines, rejects partial or illegal sequences (pedestrians, cars that reverse out), and recovers from stalled sequences with a timeout.

## Interface
- `DEBOUNCE`, default 4: consecutive cycles a synchronized sensor bit must hold a new value before it is accepted; legal range ≥1.
- `TIMEOUT`, default 1024: cycles a non-idle sequence may stall with no filtered-input change before it is abandoned; legal range ≥2.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `a` input 1: outer sensor, raw and asynchronous; 1 = beam blocked.
- `b` input 1: inner sensor, raw and asynchronous; 1 = beam blocked.
- `enter` output 1: one-cycle pulse when an entry completes.
- `exit` output 1: one-cycle pulse when an exit completes.
- `busy` output 1: high while the FSM is not in IDLE.
- `fault` output 1: high while the FSM is in WAIT_CLEAR.

## Operation
- **Synchronizer.** Each of `a` and `b` passes through 2 flops, giving `a_s` and `b_s`.
- **Debounce (per bit, independent).**
  - A counter increments while the synced bit differs from its filtered bit.
  - The counter clears when the two are equal.
  - When the counter reaches `DEBOUNCE-1` with the bits still different, the filtered bit takes the synced value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE+1)`.
  - The filtered pair is written `ab = {a_f, b_f}`.
- **FSM states:** IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLEAR. It is evaluated on `ab` every cycle.
  - IDLE: 10 → EN1; 01 → EX1; 11 → WAIT_CLEAR; 00 → stay.
  - EN1: 11 → EN2; 00 → IDLE (no pulse); 01 → WAIT_CLEAR.
  - EN2: 01 → EN3; 10 → EN1; 00 → WAIT_CLEAR.
  - EN3: 00 → IDLE and `enter` pulse; 11 → EN2; 10 → WAIT_CLEAR.
  - EX1, EX2, EX3 mirror EN1–EN3 with `a` and `b` swapped. EX3 with 00 → IDLE and `exit` pulse.
  - In every state, a pattern equal to the state's own pattern means stay.
  - WAIT_CLEAR: 00 → IDLE; anything else → stay. No pulse is ever produced on leaving WAIT_CLEAR.
- **Stall timer.**
  - Active only in EN1–EN3 and EX1–EX3.
  - Clears on any change of `ab`, and in IDLE and WAIT_CLEAR.
  - Otherwise increments each cycle.
  - On reaching `TIMEOUT-1`, the next state is WAIT_CLEAR, overriding other transitions that cycle. The timer then clears.
  - Timer width is `$clog2(TIMEOUT+1)`.
- **Outputs.**
  - `enter` and `exit` are registered and are never high in the same cycle.
  - `busy` = (state != IDLE). `fault` = (state == WAIT_CLEAR). Both are decoded from registered state.
- **Reset.**
  - Clears: sync flops to 0, `ab` to 00, debounce counters to 0, stall timer to 0, state to IDLE, `enter`/`exit` to 0.
  - Resulting outputs: `enter`=0, `exit`=0, `busy`=0, `fault`=0.
  - Reset mid-sequence abandons that sequence; no pulse is ever emitted for it.
  - If sensors are blocked when reset releases, the filtered input starts at 00, so an apparent jump to 11 goes to WAIT_CLEAR.

## Timing
- **Raw to filtered latency.** A raw change first sampled at edge k appears on the filtered bit after edge k+1+DEBOUNCE, provided it is held stable.
- **Filtered to FSM latency.** The state and the `enter`/`exit` register update at the next edge, k+2+DEBOUNCE.
- **Pulse width.** Each completion gives exactly one cycle of `enter`/`exit`.
- **Glitch rejection.** A raw glitch held for fewer than DEBOUNCE cycles at the synchronizer output never reaches `ab`.
- **Simultaneous bit changes.** When both bits change in the same cycle, e.g. 10→01, the FSM takes one transition on the combined new pattern; this normally leads to WAIT_CLEAR.
- **Back-to-back cars.** There is no minimum gap beyond returning through 00. EN3→IDLE followed immediately by 10 → EN1 is legal on consecutive cycles.

## Test plan
All scenarios use DEBOUNCE=2, TIMEOUT=16.
1. **Entry.** Hold `ab` at 00, 10, 11, 01, 00, each for 10 cycles → exactly one `enter` pulse, 4 cycles after `b` falls (raw); `exit` stays 0; `busy` is high from 4 cycles after `a` rises until the pulse.
2. **Exit, then entry.** Exit sequence 01, 11, 10, 00, then an immediate entry sequence → one `exit` pulse, then one `enter` pulse; never both in one cycle.
3. **Reversal.** 10, 11, 10, 00 (car backs out) → no pulse; `busy` returns to 0; `fault` stays 0.
4. **Glitch and illegal jump.**
   - 1-cycle raw pulse on `a` → no state change.
   - 00 → 11 held → `fault`=1 until 00 is held for 2 cycles, then `fault`=0; no pulse.
5. **Timeout.** Enter 10, 11, then hold 11 for 20 cycles → `fault` rises 16 cycles after EN2 is entered; a later 01, 00 produces no `enter`.
6. **Reset mid-operation.** Assert reset for 1 cycle while in EN3 → next cycle `busy`=0 and `fault`=0; releasing to 00 gives no `enter`.

Source files
------------

// File: rtl/lot_sensor_fsm.sv
// Gate sensor decoder: synchronizes and debounces the two beam sensors and
// turns complete a/b passage sequences into single-cycle enter/exit pulses.
module lot_sensor_fsm #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic busy,
    output logic fault
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EN1        = 3'd1,
        EN2        = 3'd2,
        EN3        = 3'd3,
        EX1        = 3'd4,
        EX2        = 3'd5,
        EX3        = 3'd6,
        WAIT_CLEAR = 3'd7
    } state_t;

    // Bit 1 carries the outer sensor a, bit 0 the inner sensor b.
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    ab_r;
    logic [1:0]    ab_prev_r;
    logic [DW-1:0] db_cnt_r [2];
    logic [TW-1:0] stall_r;
    state_t        state_r;
    state_t        fsm_next_s;
    state_t        state_next_s;
    logic          enter_r;
    logic          exit_r;
    logic          enter_next_s;
    logic          exit_next_s;
    logic          active_s;
    logic          timeout_s;

    // Two-flop synchronizer for the raw sensor lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {a, b};
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: accept a new synced value only after it has held long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_r      <= 2'b00;
            ab_prev_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            ab_prev_r <= ab_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != ab_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        ab_r[i]     <= sync2_r[i];
                        db_cnt_r[i] <= {DW{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
                    end
                end else begin
                    db_cnt_r[i] <= {DW{1'b0}};
                end
            end
        end
    end

    assign active_s  = (state_r != IDLE) && (state_r != WAIT_CLEAR);
    assign timeout_s = active_s && (stall_r == TO_LAST);

    // Stall timer: counts cycles a passage sits with no filtered-input change.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= {TW{1'b0}};
        end else if (!active_s || timeout_s || (ab_r != ab_prev_r)) begin
            stall_r <= {TW{1'b0}};
        end else begin
            stall_r <= stall_r + TW'(1);
        end
    end

    // Passage decoder; a stall timeout overrides whatever the pattern asks for.
    always_comb begin
        fsm_next_s   = state_r;
        enter_next_s = 1'b0;
        exit_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                case (ab_r)
                    2'b10:   fsm_next_s = EN1;
                    2'b01:   fsm_next_s = EX1;
                    2'b11:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = IDLE;
                endcase
            end
            EN1: begin
                case (ab_r)
                    2'b11:   fsm_next_s = EN2;
                    2'b00:   fsm_next_s = IDLE;
                    2'b01:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = EN1;
                endcase
            end
            EN2: begin
                case (ab_r)
                    2'b01:   fsm_next_s = EN3;
                    2'b10:   fsm_next_s = EN1;
                    2'b00:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = EN2;
                endcase
            end
            EN3: begin
                case (ab_r)
                    2'b00: begin
                        fsm_next_s   = IDLE;
                        enter_next_s = 1'b1;
                    end
                    2'b11:   fsm_next_s = EN2;
                    2'b10:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = EN3;
                endcase
            end
            EX1: begin
                case (ab_r)
                    2'b11:   fsm_next_s = EX2;
                    2'b00:   fsm_next_s = IDLE;
                    2'b10:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = EX1;
                endcase
            end
            EX2: begin
                case (ab_r)
                    2'b10:   fsm_next_s = EX3;
                    2'b01:   fsm_next_s = EX1;
                    2'b00:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = EX2;
                endcase
            end
            EX3: begin
                case (ab_r)
                    2'b00: begin
                        fsm_next_s  = IDLE;
                        exit_next_s = 1'b1;
                    end
                    2'b11:   fsm_next_s = EX2;
                    2'b01:   fsm_next_s = WAIT_CLEAR;
                    default: fsm_next_s = EX3;
                endcase
            end
            WAIT_CLEAR: begin
                case (ab_r)
                    2'b00:   fsm_next_s = IDLE;
                    default: fsm_next_s = WAIT_CLEAR;
                endcase
            end
            default: fsm_next_s = IDLE;
        endcase
        state_next_s = timeout_s ? WAIT_CLEAR : fsm_next_s;
        if (timeout_s) begin
            enter_next_s = 1'b0;
            exit_next_s  = 1'b0;
        end else begin
            enter_next_s = enter_next_s;
            exit_next_s  = exit_next_s;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            enter_r <= 1'b0;
            exit_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            enter_r <= enter_next_s;
            exit_r  <= exit_next_s;
        end
    end

    assign enter = enter_r;
    assign exit  = exit_r;
    assign busy  = (state_r != IDLE);
    assign fault = (state_r == WAIT_CLEAR);

endmodule

// File: tb/tb_lot_sensor_fsm.sv
// Directed bench for lot_sensor_fsm with DEBOUNCE=2, TIMEOUT=16.
module tb_lot_sensor_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic a     = 1'b0;
    logic b     = 1'b0;
    logic enter;
    logic exit;
    logic busy;
    logic fault;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int enter_cnt = 0;
    int exit_cnt = 0;
    int both_cnt = 0;
    int fault_cnt = 0;
    int busy_cnt = 0;
    int e0, x0, f0, b0;

    lot_sensor_fsm #(.DEBOUNCE(2), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .enter (enter),
        .exit  (exit),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (enter) enter_cnt++;
        if (exit) exit_cnt++;
        if (enter && exit) both_cnt++;
        if (fault) fault_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input int n);
        a = va;
        b = vb;
        step(n);
    endtask

    task automatic snap();
        e0 = enter_cnt;
        x0 = exit_cnt;
        f0 = fault_cnt;
        b0 = busy_cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        step(3);
        check_val("rst_enter", enter, 0);
        check_val("rst_exit", exit, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_fault", fault, 0);
        reset = 1'b0;
        step(2);

        // 1. entry with exact latency checks
        snap();
        drive(1'b1, 1'b0, 4);
        check_val("s1_busy_early", busy, 0);
        step(1);
        check_val("s1_busy_rise", busy, 1);
        step(5);
        drive(1'b1, 1'b1, 10);
        check_val("s1_busy_en2", busy, 1);
        drive(1'b0, 1'b1, 10);
        check_val("s1_busy_en3", busy, 1);
        drive(1'b0, 1'b0, 4);
        check_val("s1_enter_early", enter, 0);
        step(1);
        check_val("s1_enter_pulse", enter, 1);
        step(1);
        check_val("s1_enter_width", enter, 0);
        check_val("s1_busy_done", busy, 0);
        step(8);
        check_val("s1_enter_cnt", enter_cnt - e0, 1);
        check_val("s1_exit_cnt", exit_cnt - x0, 0);

        // 2. exit, short gap through 00, then entry
        snap();
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 10);
        check_val("s2_exit_cnt", exit_cnt - x0, 1);
        check_val("s2_enter_mid", enter_cnt - e0, 0);
        check_val("s2_busy_en1", busy, 1);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        check_val("s2_enter_cnt", enter_cnt - e0, 1);
        check_val("s2_exit_total", exit_cnt - x0, 1);

        // 3. reversal: car backs out
        snap();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        check_val("s3_pulses", (enter_cnt - e0) + (exit_cnt - x0), 0);
        check_val("s3_busy", busy, 0);
        check_val("s3_fault_cnt", fault_cnt - f0, 0);

        // 3b. simultaneous 10 -> 01 jump from EN1
        snap();
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 10);
        check_val("s3b_fault", fault, 1);
        drive(1'b0, 1'b0, 10);
        check_val("s3b_fault_clr", fault, 0);
        check_val("s3b_busy", busy, 0);
        check_val("s3b_pulses", (enter_cnt - e0) + (exit_cnt - x0), 0);

        // 4a. one-cycle glitch on a
        snap();
        a = 1'b1;
        step(1);
        a = 1'b0;
        step(10);
        check_val("s4_glitch_busy", busy_cnt - b0, 0);

        // 4b. illegal 00 -> 11 jump
        snap();
        drive(1'b1, 1'b1, 10);
        check_val("s4_fault", fault, 1);
        drive(1'b0, 1'b0, 4);
        check_val("s4_fault_hold", fault, 1);
        step(1);
        check_val("s4_fault_clr", fault, 0);
        step(5);
        check_val("s4_pulses", (enter_cnt - e0) + (exit_cnt - x0), 0);

        // 5. stall timeout in EN2
        snap();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 20);
        check_val("s5_fault_early", fault, 0);
        step(1);
        check_val("s5_fault_rise", fault, 1);
        step(4);
        drive(1'b0, 1'b1, 10);
        check_val("s5_fault_hold", fault, 1);
        drive(1'b0, 1'b0, 10);
        check_val("s5_fault_clr", fault, 0);
        check_val("s5_enter_cnt", enter_cnt - e0, 0);

        // 6. reset while in EN3
        snap();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        check_val("s6_busy_en3", busy, 1);
        reset = 1'b1;
        a = 1'b0;
        b = 1'b0;
        step(1);
        check_val("s6_busy_rst", busy, 0);
        check_val("s6_fault_rst", fault, 0);
        reset = 1'b0;
        step(10);
        check_val("s6_enter_cnt", enter_cnt - e0, 0);
        check_val("s6_busy_end", busy, 0);

        check_val("both_pulses", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
